// File: rtl/adder_share_arbiter_if.sv
// adder_share_arbiter_if: request/result bus between client blocks and the shared adder arbiter
interface adder_share_arbiter_if #(
    parameter int WIDTH = 16,
    parameter int NREQ  = 4
) ();
    logic [NREQ-1:0]       req_valid;
    logic [NREQ-1:0]       req_ready;
    logic [NREQ*WIDTH-1:0] req_a;
    logic [NREQ*WIDTH-1:0] req_b;
    logic                  res_valid;
    logic                  res_ready;
    logic [WIDTH:0]        res_sum;
    logic [2:0]            res_id;

    modport master (
        output req_valid, req_a, req_b, res_ready,
        input  req_ready, res_valid, res_sum, res_id
    );

    modport slave (
        input  req_valid, req_a, req_b, res_ready,
        output req_ready, res_valid, res_sum, res_id
    );
endinterface

// File: rtl/adder_share_arbiter.sv
// adder_share_arbiter: round-robin sharing of one ripple-carry adder among NREQ requesters
module adder_share_arbiter #(
    parameter int WIDTH         = 16,
    parameter int NREQ          = 4,
    parameter int SETTLE_CYCLES = 2
) (
    input  logic                 clk,
    input  logic                 rst_n,
    adder_share_arbiter_if.slave bus,
    output logic                 busy,
    output logic [7:0]           ovf_count
);
    typedef enum logic [1:0] {IDLE, SETTLE, HOLD} state_t;

    state_t           state, state_nx;
    logic [WIDTH-1:0] op_a, op_b;
    logic [3:0]       cnt;
    logic [2:0]       last_id, win;
    logic             found, handshake, capture;
    logic [WIDTH:0]   carry, sum;
    int               best, d;

    assign carry[0]   = 1'b0;
    assign sum[WIDTH] = carry[WIDTH];

    for (genvar i = 0; i < WIDTH; i++) begin : g_rca
        assign sum[i]     = op_a[i] ^ op_b[i] ^ carry[i];
        assign carry[i+1] = (op_a[i] & op_b[i]) | (carry[i] & (op_a[i] ^ op_b[i]));
    end

    assign busy = state != IDLE;

    // round-robin pick: the valid requester closest after last_id wins
    always_comb begin
        found = 1'b0;
        win   = '0;
        best  = NREQ;
        d     = 0;
        for (int j = 0; j < NREQ; j++) begin
            d = (j + 2 * NREQ - int'(last_id) - 1) % NREQ;
            if (bus.req_valid[j] && d < best) begin
                best  = d;
                win   = 3'(j);
                found = 1'b1;
            end
        end
    end

    // grant, capture strobes and next state
    always_comb begin
        handshake     = state == IDLE && found;
        capture       = state == SETTLE && cnt == 4'd0;
        bus.req_ready = handshake ? NREQ'(1) << win : '0;
        state_nx      = state == IDLE   ? (found ? SETTLE : IDLE) :
                        state == SETTLE ? (capture ? HOLD : SETTLE) :
                                          (bus.res_ready ? IDLE : HOLD);
    end

    // state register
    always_ff @(posedge clk) begin
        if (!rst_n)
            state <= IDLE;
        else
            state <= state_nx;
    end

    // operand latch, settle counter, result register and carry-out statistics
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            op_a          <= '0;
            op_b          <= '0;
            cnt           <= '0;
            last_id       <= 3'(NREQ - 1);
            bus.res_sum   <= '0;
            bus.res_id    <= '0;
            bus.res_valid <= 1'b0;
            ovf_count     <= '0;
        end else begin
            if (handshake) begin
                op_a       <= bus.req_a[int'(win) * WIDTH +: WIDTH];
                op_b       <= bus.req_b[int'(win) * WIDTH +: WIDTH];
                bus.res_id <= win;
                last_id    <= win;
                cnt        <= 4'(SETTLE_CYCLES - 1);
            end else if (state == SETTLE && cnt != 4'd0) begin
                cnt <= cnt - 4'd1;
            end
            if (capture) begin
                bus.res_sum   <= sum;
                bus.res_valid <= 1'b1;
                if (sum[WIDTH] && ovf_count != 8'hFF)
                    ovf_count <= ovf_count + 8'd1;
            end else if (state == HOLD && bus.res_ready) begin
                bus.res_valid <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_adder_share_arbiter.sv
// tb_adder_share_arbiter: scoreboard bench for the shared-adder arbiter
module tb_adder_share_arbiter;
    localparam int W = 16;
    localparam int N = 4;
    localparam int S = 2;

    typedef struct {
        logic [W:0] sum;
        logic [2:0] id;
        int         hcyc;
    } exp_t;

    logic       clk;
    logic       rst_n;
    logic       busy;
    logic [7:0] ovf_count;

    adder_share_arbiter_if #(.WIDTH(W), .NREQ(N)) bus ();

    adder_share_arbiter #(.WIDTH(W), .NREQ(N), .SETTLE_CYCLES(S)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .bus       (bus),
        .busy      (busy),
        .ovf_count (ovf_count)
    );

    exp_t       sb[$];
    int         grants[$];
    int         gcyc[$];
    int         checks, errors, cyc, model_last;
    logic       prev_valid;
    logic [3:0] obs_ready;

    always #5 clk = ~clk;

    function automatic int rr_pick(logic [3:0] v, int last);
        for (int k = 1; k <= N; k++)
            if (v[(last + k) % N]) return (last + k) % N;
        return -1;
    endfunction

    // one cycle: inputs already driven at negedge; observe, then advance to next negedge
    task automatic tick();
        int   w;
        exp_t e;
        #1;
        obs_ready = bus.req_ready;
        checks++;
        if ($countones(bus.req_ready) > 1) begin
            errors++;
            $display("FAIL onehot: req_ready=%b, at most one bit allowed", bus.req_ready);
        end
        if (bus.req_ready != 0) begin
            w = rr_pick(bus.req_valid, model_last);
            checks++;
            if (w < 0 || bus.req_ready !== 4'(1 << w)) begin
                errors++;
                $display("FAIL grant: req_ready=%b expected winner %0d (valid=%b)", bus.req_ready, w, bus.req_valid);
            end else begin
                e.sum  = {1'b0, bus.req_a[w*W +: W]} + {1'b0, bus.req_b[w*W +: W]};
                e.id   = 3'(w);
                e.hcyc = cyc;
                sb.push_back(e);
                model_last = w;
                grants.push_back(w);
                gcyc.push_back(cyc);
            end
        end
        if (bus.res_valid && !prev_valid && sb.size() > 0) begin
            checks++;
            if (cyc - sb[0].hcyc != S + 1) begin
                errors++;
                $display("FAIL latency: %0d cycles, expected %0d", cyc - sb[0].hcyc, S + 1);
            end
        end
        if (bus.res_valid && bus.res_ready) begin
            checks++;
            if (sb.size() == 0) begin
                errors++;
                $display("FAIL unexpected_result: sum=%h id=%0d with no pending operation", bus.res_sum, bus.res_id);
            end else begin
                e = sb.pop_front();
                if (bus.res_sum !== e.sum || bus.res_id !== e.id) begin
                    errors++;
                    $display("FAIL result: sum=%h id=%0d expected sum=%h id=%0d", bus.res_sum, bus.res_id, e.sum, e.id);
                end
            end
        end
        prev_valid = bus.res_valid;
        @(negedge clk);
        cyc++;
    endtask

    task automatic drain();
        int n = 0;
        bus.res_ready = 1'b1;
        while ((sb.size() > 0 || bus.res_valid) && n < 40) begin
            tick();
            n++;
        end
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL drain_timeout: %0d results outstanding, expected 0", sb.size());
        end
    endtask

    task automatic do_op(int id, logic [W-1:0] a, logic [W-1:0] b);
        int n0 = grants.size();
        bus.req_a[id*W +: W] = a;
        bus.req_b[id*W +: W] = b;
        bus.req_valid = 4'(1 << id);
        bus.res_ready = 1'b1;
        tick();
        bus.req_valid = '0;
        bus.req_a = '1;
        bus.req_b = '1;
        checks++;
        if (grants.size() != n0 + 1) begin
            errors++;
            $display("FAIL op_grant: %0d grants, expected %0d", grants.size(), n0 + 1);
        end
        checks++;
        if (busy !== 1'b1) begin
            errors++;
            $display("FAIL busy_after_grant: busy=%b expected 1", busy);
        end
        drain();
    endtask

    task automatic test_reset();
        bus.req_valid = '0;
        bus.res_ready = 1'b0;
        rst_n = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
        sb.delete();
        grants.delete();
        gcyc.delete();
        model_last = N - 1;
        prev_valid = 1'b0;
        checks++;
        if (bus.res_valid !== 1'b0 || bus.res_sum !== '0 || bus.res_id !== '0 || ovf_count !== 8'd0 || busy !== 1'b0 || bus.req_ready !== '0) begin
            errors++;
            $display("FAIL reset: valid=%b sum=%h id=%0d ovf=%0d busy=%b ready=%b expected all zero",
                     bus.res_valid, bus.res_sum, bus.res_id, ovf_count, busy, bus.req_ready);
        end
    endtask

    task automatic test_basic();
        do_op(0, 16'h1234, 16'h0001);
        checks++;
        if (ovf_count !== 8'd0) begin
            errors++;
            $display("FAIL basic_ovf: ovf_count=%0d expected 0", ovf_count);
        end
    endtask

    task automatic test_carry();
        do_op(2, 16'hFFFF, 16'h0001);
        checks++;
        if (ovf_count !== 8'd1) begin
            errors++;
            $display("FAIL carry_ovf1: ovf_count=%0d expected 1", ovf_count);
        end
        do_op(2, 16'hFFFF, 16'hFFFF);
        checks++;
        if (ovf_count !== 8'd2) begin
            errors++;
            $display("FAIL carry_ovf2: ovf_count=%0d expected 2", ovf_count);
        end
        do_op(1, 16'hA5A5, 16'h5A5A);
        do_op(3, 16'h0000, 16'h0000);
    endtask

    task automatic test_round_robin();
        int n = 0;
        test_reset();
        for (int i = 0; i < N; i++) begin
            bus.req_a[i*W +: W] = 16'(16'h1111 * (i + 1));
            bus.req_b[i*W +: W] = 16'(16'h0F0F + i);
        end
        bus.req_valid = 4'b1111;
        bus.res_ready = 1'b1;
        while (grants.size() < 6 && n < 60) begin
            tick();
            n++;
        end
        bus.req_valid = '0;
        drain();
        checks++;
        if (grants.size() < 6) begin
            errors++;
            $display("FAIL rr_timeout: %0d grants, expected 6", grants.size());
        end else begin
            for (int k = 0; k < 6; k++) begin
                checks++;
                if (grants[k] != k % N) begin
                    errors++;
                    $display("FAIL rr_order[%0d]: granted %0d expected %0d", k, grants[k], k % N);
                end
                if (k > 0) begin
                    checks++;
                    if (gcyc[k] - gcyc[k-1] != S + 2) begin
                        errors++;
                        $display("FAIL rr_spacing[%0d]: %0d cycles expected %0d", k, gcyc[k] - gcyc[k-1], S + 2);
                    end
                end
            end
        end
    endtask

    task automatic test_backpressure();
        logic [W:0] hold_sum;
        logic [2:0] hold_id;
        int         n = 0;
        bus.req_a[0 +: W] = 16'h4321;
        bus.req_b[0 +: W] = 16'h1111;
        bus.req_a[W +: W] = 16'h0101;
        bus.req_b[W +: W] = 16'h0202;
        bus.req_valid = 4'b0001;
        bus.res_ready = 1'b0;
        tick();
        bus.req_valid = '0;
        while (!bus.res_valid && n < 10) begin
            tick();
            n++;
        end
        checks++;
        if (!bus.res_valid) begin
            errors++;
            $display("FAIL bp_timeout: res_valid=0 expected 1");
        end
        hold_sum = bus.res_sum;
        hold_id  = bus.res_id;
        bus.req_valid = 4'b0010;
        for (int k = 0; k < 5; k++) begin
            tick();
            checks++;
            if (bus.res_valid !== 1'b1 || bus.res_sum !== hold_sum || bus.res_id !== hold_id || obs_ready !== 4'b0000) begin
                errors++;
                $display("FAIL bp_hold[%0d]: valid=%b sum=%h id=%0d ready=%b expected 1 %h %0d 0000",
                         k, bus.res_valid, bus.res_sum, bus.res_id, obs_ready, hold_sum, hold_id);
            end
        end
        bus.res_ready = 1'b1;
        tick();
        tick();
        checks++;
        if (obs_ready !== 4'b0010) begin
            errors++;
            $display("FAIL bp_regrant: req_ready=%b expected 0010", obs_ready);
        end
        bus.req_valid = '0;
        drain();
    endtask

    task automatic test_reset_midflight();
        bus.req_a[0 +: W] = 16'h7777;
        bus.req_b[0 +: W] = 16'h9999;
        bus.req_valid = 4'b0001;
        bus.res_ready = 1'b1;
        tick();
        bus.req_valid = '0;
        tick();
        rst_n = 1'b0;
        tick();
        checks++;
        if (busy !== 1'b0 || bus.res_valid !== 1'b0 || ovf_count !== 8'd0) begin
            errors++;
            $display("FAIL midreset: busy=%b res_valid=%b ovf=%0d expected 0 0 0", busy, bus.res_valid, ovf_count);
        end
        rst_n = 1'b1;
        sb.delete();
        model_last = N - 1;
        prev_valid = 1'b0;
        for (int k = 0; k < 6; k++) tick();
        bus.req_a[3*W +: W] = 16'h0003;
        bus.req_b[3*W +: W] = 16'h0004;
        bus.req_a[0 +: W] = 16'h0001;
        bus.req_b[0 +: W] = 16'h0002;
        bus.req_valid = 4'b1001;
        tick();
        bus.req_valid = '0;
        checks++;
        if (obs_ready !== 4'b0001) begin
            errors++;
            $display("FAIL midreset_priority: req_ready=%b expected 0001", obs_ready);
        end
        drain();
    endtask

    task automatic test_back_to_back();
        int n = 0;
        test_reset();
        bus.req_a[0 +: W] = 16'h8000;
        bus.req_b[0 +: W] = 16'h8000;
        bus.req_valid = 4'b0001;
        bus.res_ready = 1'b1;
        while (grants.size() < 260 && n < 1300) begin
            tick();
            n++;
        end
        bus.req_valid = '0;
        drain();
        checks++;
        if (grants.size() != 260) begin
            errors++;
            $display("FAIL b2b_count: %0d grants expected 260", grants.size());
        end
        checks++;
        if (ovf_count !== 8'hFF) begin
            errors++;
            $display("FAIL b2b_saturate: ovf_count=%h expected ff", ovf_count);
        end
    endtask

    initial begin
        clk = 1'b0;
        rst_n = 1'b0;
        bus.req_valid = '0;
        bus.req_a = '0;
        bus.req_b = '0;
        bus.res_ready = 1'b0;
        checks = 0;
        errors = 0;
        cyc = 0;
        model_last = N - 1;
        prev_valid = 1'b0;
        obs_ready = '0;
        @(negedge clk);
        test_reset();
        test_basic();
        test_carry();
        test_round_robin();
        test_backpressure();
        test_reset_midflight();
        test_back_to_back();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
